exp_vend: RTL and testbench
===========================

Name: exp_vend

Overview:
- Moore-type coin-operated vending controller for a single item priced at 15 currency units.
- Accepts 5-unit and 10-unit coin-sense pulses and accumulates credit.
- Asserts a one-cycle dispense strobe when credit reaches 15 or more.
- If overpaid (20), also asserts a one-cycle 5-unit change-return strobe.
- Sits between the coin-acceptor sense logic and the dispenser/change-return actuators.

Parameters:
- None. Price (15), coin values (5, 10) and change value (5) are fixed constants in the package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the idle state immediately.
- rs5  input  1  5-unit coin inserted; sampled on rising clk, one coin per cycle high.
- rs10  input  1  10-unit coin inserted; sampled on rising clk, one coin per cycle high.
- rs5out  output  1  return 5-unit change; high for exactly one cycle.
- item1  output  1  dispense one item; high for exactly one cycle.
- sales_cnt  output  8  dispensed-item count; present only with VEND_SALES_CNT_EN.

Behaviour:
- One clock, clk. reset is asynchronous and active-low.
- Pure Moore machine: rs5out and item1 are decoded from the state register only; inputs never affect outputs combinationally.
- States and outputs:
  - IDLE (credit 0): item1=0, rs5out=0
  - C5 (credit 5): item1=0, rs5out=0
  - C10 (credit 10): item1=0, rs5out=0
  - VEND (credit exactly 15): item1=1, rs5out=0
  - VEND_CHG (credit 20): item1=1, rs5out=1
- Coin decode each rising edge:
  - rs10=1 means coin 10, regardless of rs5; rs10 has priority when both are high, and the 5 is ignored.
  - rs5=1 with rs10=0 means coin 5.
  - Both low means no coin.
- Base credit is 0 in IDLE, VEND and VEND_CHG, and 5 or 10 in C5 or C10.
- Next state from total = base + coin:
  - 0 → IDLE; 5 → C5; 10 → C10; 15 → VEND; 20 → VEND_CHG.
- VEND and VEND_CHG last exactly one cycle. A coin sampled on the edge that leaves them starts a new transaction, so back-to-back vends are possible with no idle cycle.
- With no coin, C5 and C10 hold their credit indefinitely; there is no timeout.
- Latency: the coin is sampled at edge N. The resulting outputs are valid from just after edge N until edge N+1.
- Reset:
  - Asserting reset (low) at any time, including mid-transaction or during VEND/VEND_CHG, forces IDLE asynchronously.
  - item1=0 and rs5out=0 immediately; accumulated credit is discarded.
  - On reset release, the first rising edge with reset=1 evaluates normally.
- State encoding is implementer's choice; unreachable encodings must recover to IDLE.

Optional Feature:
- Macro VEND_SALES_CNT_EN.
- Defined:
  - Adds output sales_cnt[7:0], reset to 0 asynchronously.
  - Increments by 1 on each rising edge on which the machine enters VEND or VEND_CHG.
  - Wraps from 255 to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package exp_vend_pkg holds:
  - state_t enum (IDLE, C5, C10, VEND, VEND_CHG)
  - constants PRICE=15, COIN5=5, COIN10=10
- Single module, no sub-modules; next-state logic, state register and output decode are three blocks within it.

Test Plan:
- Reset held low, then released with no coins → IDLE; item1=0, rs5out=0 every cycle.
- rs10 then rs5 on consecutive edges → C10, then VEND: item1=1 for one cycle, rs5out=0, then IDLE.
- rs10, rs10 → VEND_CHG: item1=1 and rs5out=1 for one cycle. rs5 ×3 → C5, C10, VEND.
- Priority case: rs5=1 and rs10=1 together from IDLE → C10. Then rs10 → VEND_CHG (item1=1, rs5out=1).
- Back-to-back: rs10, rs10, rs5, rs5, rs5 → VEND_CHG, then C5 (coin on the exit edge), C10, VEND; two dispenses.
- reset pulsed low while in C10 → immediately IDLE. Following rs5 → C5, no dispense. With VEND_SALES_CNT_EN, sales_cnt tracks dispense count and wraps 255→0.

Source files
------------

// File: rtl/exp_vend_pkg.sv
// exp_vend shared types and fixed coin/price constants.
// Optional sales counter is enabled with VEND_SALES_CNT_EN.
package exp_vend_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        C5       = 3'd1,
        C10      = 3'd2,
        VEND     = 3'd3,
        VEND_CHG = 3'd4
    } state_t;

    localparam logic [4:0] PRICE  = 5'd15;
    localparam logic [4:0] COIN5  = 5'd5;
    localparam logic [4:0] COIN10 = 5'd10;
    localparam logic [4:0] CHANGE = 5'd5;

    function automatic logic [4:0] base_credit(state_t s);
        logic [4:0] c;
        c = 5'd0;
        case (s)
            C5:      c = COIN5;
            C10:     c = COIN10;
            default: c = 5'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp_vend.sv
// Moore vending controller: 15-unit item, 5/10 coins, 5 change.
// Define VEND_SALES_CNT_EN to add the sales_cnt output.
module exp_vend
    import exp_vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rs5,
    input  logic       rs10,
    output logic       rs5out,
    output logic       item1
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [7:0] sales_cnt
`endif
);

    state_t     state;
    state_t     next;
    logic [4:0] coin;
    logic [4:0] total;
    logic       legal;

    always_comb begin
        coin  = 5'd0;
        total = 5'd0;
        legal = 1'b0;
        next  = IDLE;
        // rs10 wins when both sense lines are high
        if (rs10)
            coin = COIN10;
        else if (rs5)
            coin = COIN5;
        case (state)
            IDLE, C5, C10, VEND, VEND_CHG: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        total = base_credit(state) + coin;
        if (!legal)
            next = IDLE;
        else if (total == PRICE + CHANGE)
            next = VEND_CHG;
        else if (total == PRICE)
            next = VEND;
        else if (total == COIN10)
            next = C10;
        else if (total == COIN5)
            next = C5;
        else
            next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        item1  = 1'b0;
        rs5out = 1'b0;
        case (state)
            VEND: begin
                item1 = 1'b1;
            end
            VEND_CHG: begin
                item1  = 1'b1;
                rs5out = 1'b1;
            end
            default: begin
                item1  = 1'b0;
                rs5out = 1'b0;
            end
        endcase
    end

`ifdef VEND_SALES_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sales_cnt <= 8'd0;
        else if (next == VEND || next == VEND_CHG)
            sales_cnt <= sales_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_exp_vend.sv
// Directed self-checking bench for exp_vend.
// Sales counter checks are built when VEND_SALES_CNT_EN is defined.
module tb_exp_vend;

    logic       clk;
    logic       reset;
    logic       rs5;
    logic       rs10;
    logic       rs5out;
    logic       item1;
`ifdef VEND_SALES_CNT_EN
    logic [7:0] sales_cnt;
    logic [7:0] exp_cnt;
`endif

    int checks;
    int failures;

    exp_vend dut (
        .clk    (clk),
        .reset  (reset),
        .rs5    (rs5),
        .rs10   (rs10),
        .rs5out (rs5out),
        .item1  (item1)
`ifdef VEND_SALES_CNT_EN
        ,
        .sales_cnt (sales_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive coin lines, clock once, land 1ns after the edge
    task automatic step(input logic c5, input logic c10);
        rs5  = c5;
        rs10 = c10;
        @(posedge clk);
        #1;
        rs5  = 1'b0;
        rs10 = 1'b0;
    endtask

    task automatic expect_out(input string name,
                              input logic e_item,
                              input logic e_chg);
        checks++;
        if (item1 !== e_item || rs5out !== e_chg) begin
            failures++;
            $display("FAIL %s: item1=%b rs5out=%b expected item1=%b rs5out=%b",
                     name, item1, rs5out, e_item, e_chg);
        end
`ifdef VEND_SALES_CNT_EN
        if (e_item === 1'b1)
            exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (sales_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL %s_cnt: sales_cnt=%0d expected %0d",
                     name, sales_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rs5   = 1'b0;
        rs10  = 1'b0;
`ifdef VEND_SALES_CNT_EN
        exp_cnt = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset_held", 1'b0, 1'b0);
        // coins while held in reset must be ignored
        step(1'b0, 1'b1);
        expect_out("reset_coin_ignored", 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            expect_out("reset_idle", 1'b0, 1'b0);
        end
    endtask

    task automatic test_vend_exact();
        step(1'b0, 1'b1);
        expect_out("exact_c10", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("exact_vend", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("exact_idle", 1'b0, 1'b0);
    endtask

    task automatic test_vend_change();
        step(1'b0, 1'b1);
        expect_out("chg_c10", 1'b0, 1'b0);
        step(1'b0, 1'b1);
        expect_out("chg_vend", 1'b1, 1'b1);
        step(1'b0, 1'b0);
        expect_out("chg_idle", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("five_c5", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("five_c10", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("five_vend", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("five_idle", 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        step(1'b1, 1'b1);
        expect_out("prio_c10", 1'b0, 1'b0);
        // from C10 a 10 gives change; from C5 it would not
        step(1'b0, 1'b1);
        expect_out("prio_vend_chg", 1'b1, 1'b1);
        step(1'b1, 1'b0);
        expect_out("prio_c5", 1'b0, 1'b0);
        step(1'b1, 1'b1);
        expect_out("prio_c5_plus10", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("prio_idle", 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        step(1'b1, 1'b0);
        expect_out("hold_c5", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            expect_out("hold_wait", 1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        expect_out("hold_c10", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("hold_vend", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("hold_idle", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1);
        expect_out("b2b_c10", 1'b0, 1'b0);
        step(1'b0, 1'b1);
        expect_out("b2b_vend_chg", 1'b1, 1'b1);
        step(1'b1, 1'b0);
        expect_out("b2b_c5", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("b2b_c10b", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("b2b_vend", 1'b1, 1'b0);
        step(1'b0, 1'b1);
        expect_out("b2b_c10c", 1'b0, 1'b0);
        step(1'b0, 1'b0);
        expect_out("b2b_hold", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("b2b_vend2", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_out("b2b_idle", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1);
        expect_out("mid_c10", 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
`ifdef VEND_SALES_CNT_EN
        exp_cnt = 8'd0;
`endif
        expect_out("mid_rst_c10", 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        step(1'b1, 1'b0);
        expect_out("mid_after_c5", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("mid_after_c10", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("mid_after_vend", 1'b1, 1'b0);
        // async reset in the middle of a dispense cycle
        step(1'b0, 1'b1);
        expect_out("mid_c10b", 1'b0, 1'b0);
        step(1'b0, 1'b1);
        expect_out("mid_vend_chg", 1'b1, 1'b1);
        #1;
        reset = 1'b0;
        #1;
`ifdef VEND_SALES_CNT_EN
        exp_cnt = 8'd0;
`endif
        expect_out("mid_rst_vend", 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b0);
        expect_out("mid_rel_idle", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("mid_rel_c5", 1'b0, 1'b0);
        step(1'b0, 1'b0);
        expect_out("mid_rel_hold", 1'b0, 1'b0);
    endtask

`ifdef VEND_SALES_CNT_EN
    task automatic test_sales_wrap();
        // C5 pending from the previous test: finish it first
        step(1'b0, 1'b1);
        expect_out("wrap_first", 1'b1, 1'b0);
        while (exp_cnt != 8'd255) begin
            step(1'b0, 1'b1);
            expect_out("wrap_c10", 1'b0, 1'b0);
            step(1'b0, 1'b1);
            expect_out("wrap_vend", 1'b1, 1'b1);
        end
        step(1'b0, 1'b1);
        expect_out("wrap_c10_last", 1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_out("wrap_to_zero", 1'b1, 1'b0);
        checks++;
        if (sales_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_zero: sales_cnt=%0d expected 0", sales_cnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef VEND_SALES_CNT_EN
        test_sales_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
